// File: rtl/aes_key_sequencer_pkg.sv
// Shared AES key-schedule definitions: sequencer state encoding, round constants, round count.
package aes_key_sequencer_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_EMIT = 2'd2,
    ST_STEP = 2'd3
  } state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Indices outside the table occur only when no step is being applied.
  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    if (i < 4'd10) r = RCON[i];
    return r;
  endfunction

endpackage

// File: rtl/aes_key_sequencer_round.sv
// One AES-128 key-schedule step, forward or inverse; the S-box lookup is done externally
// through sub_in/sub_out.
module aes_key_round (
  input  logic [127:0] key_i,
  input  logic         inv_i,
  input  logic [7:0]   rcon_i,
  output logic [31:0]  sub_in,
  input  logic [31:0]  sub_out,
  output logic [127:0] key_o
);
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] iw1, iw2, iw3;
  logic [31:0] g;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  // Inverse step recovers words 1..3 of the previous key first; its word 3 feeds G.
  assign iw1 = w1 ^ w0;
  assign iw2 = w2 ^ w1;
  assign iw3 = w3 ^ w2;

  assign sub_in = inv_i ? iw3 : w3;
  // SubWord and RotWord commute, so the rotate is applied after the lookup.
  assign g = {sub_out[23:0], sub_out[31:24]} ^ {rcon_i, 24'h000000};

  assign n0 = w0 ^ g;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_o = inv_i ? {w0 ^ g, iw1, iw2, iw3} : {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sequencer.sv
// AES-128 round-key sequencer emitting keys 0..10 or 10..0 over a ready/valid port.
// Optional feature macro: AES_KEY_CACHE_EN (caches the last round-10 key to skip PRE).
module aes_key_sequencer
  import aes_key_sequencer_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dec,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         sbox_req,
  input  logic         sbox_gnt,
  output logic [31:0]  sub_in,
  input  logic [31:0]  sub_out
);
  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         dec_q, dec_d;
  logic         inv;
  logic [3:0]   rcon_idx;
  logic [127:0] round_key;

`ifdef AES_KEY_CACHE_EN
  logic         cache_vld_q, cache_vld_d;
  logic [127:0] cache_src_q, cache_src_d;
  logic [127:0] cache_key_q, cache_key_d;
`endif

  // Inverse stepping happens only in STEP of a dec job; PRE always runs forward.
  assign inv      = (state_q == ST_STEP) && dec_q;
  assign rcon_idx = inv ? (idx_q - 4'd1) : idx_q;

  aes_key_round u_round (
    .key_i   (key_q),
    .inv_i   (inv),
    .rcon_i  (rcon_at(rcon_idx)),
    .sub_in  (sub_in),
    .sub_out (sub_out),
    .key_o   (round_key)
  );

  assign busy     = (state_q != ST_IDLE);
  assign rk_valid = (state_q == ST_EMIT);
  assign sbox_req = (state_q == ST_PRE) || (state_q == ST_STEP);
  assign rk_out   = key_q;
  assign rk_idx   = idx_q;
  assign rk_last  = rk_valid && (dec_q ? (idx_q == 4'd0) : (idx_q == LAST_IDX));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
`ifdef AES_KEY_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_src_d = cache_src_q;
    cache_key_d = cache_key_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          dec_d   = dec;
          state_d = dec ? ST_PRE : ST_EMIT;
`ifdef AES_KEY_CACHE_EN
          if (dec && cache_vld_q && (key_in == cache_src_q)) begin
            key_d   = cache_key_q;
            idx_d   = LAST_IDX;
            state_d = ST_EMIT;
          end else if (dec) begin
            // Entry is invalid until this PRE run completes; a reset mid-run leaves it invalid.
            cache_vld_d = 1'b0;
            cache_src_d = key_in;
          end
`endif
        end
      end
      ST_PRE: begin
        if (sbox_gnt) begin
          key_d = round_key;
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX - 4'd1) begin
            state_d = ST_EMIT;
`ifdef AES_KEY_CACHE_EN
            cache_vld_d = 1'b1;
            cache_key_d = round_key;
`endif
          end
        end
      end
      ST_EMIT: begin
        if (rk_ready) state_d = rk_last ? ST_IDLE : ST_STEP;
      end
      ST_STEP: begin
        if (sbox_gnt) begin
          key_d   = round_key;
          idx_d   = dec_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
          state_d = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
    end
  end

`ifdef AES_KEY_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q <= 1'b0;
      cache_src_q <= '0;
      cache_key_q <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_src_q <= cache_src_d;
      cache_key_q <= cache_key_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_sequencer.sv
// Directed bench for aes_key_sequencer using the FIPS-197 key 000102..0f schedule.
module tb_aes_key_sequencer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         dec;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         sbox_req;
  logic         sbox_gnt;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] rk_tab [11] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign sub_out = {sbox_t[sub_in[31:24]], sbox_t[sub_in[23:16]],
                    sbox_t[sub_in[15:8]],  sbox_t[sub_in[7:0]]};

  always #5 clk = ~clk;

  aes_key_sequencer #(.NR(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dec      (dec),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last),
    .sbox_req (sbox_req),
    .sbox_gnt (sbox_gnt),
    .sub_in   (sub_in),
    .sub_out  (sub_out)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  busy,     0);
    check_eq({tag, "_valid"}, rk_valid, 0);
    check_eq({tag, "_last"},  rk_last,  0);
    check_eq({tag, "_req"},   sbox_req, 0);
    check_eq({tag, "_out"},   rk_out,   0);
    check_eq({tag, "_idx"},   rk_idx,   0);
    check_eq({tag, "_subin"}, sub_in,   0);
  endtask

  // Runs one job on KEY0 and checks all 11 keys; optional ready stall at idx stall_at,
  // grant stall in the first STEP, and a foreign start pulse during the job.
  task automatic run_job(input bit d, input int stall_at, input bit gstall, input bit poke,
                         output int pre_cnt);
    int  n, ei, cyc, prev;
    bit  stalled, gdone, poked;
    n = 0; cyc = 0; pre_cnt = 0;
    stalled = 0; gdone = 0; poked = 0;
    ei = d ? 10 : 0;
    @(negedge clk);
    dec = d; key_in = KEY0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key_in = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    while (n < 11 && cyc < 300) begin
      start = 1'b0;
      if (n == 0 && sbox_req) pre_cnt++;
      if (rk_valid) begin
        if (rk_idx == 4'(stall_at) && !stalled) begin
          stalled  = 1;
          rk_ready = 1'b0;
          repeat (5) begin
            @(negedge clk); cyc++;
            check_eq("hold_out",   rk_out,   rk_tab[ei]);
            check_eq("hold_idx",   rk_idx,   ei);
            check_eq("hold_noreq", sbox_req, 0);
          end
          rk_ready = 1'b1;
        end
        check_eq("rk_out",  rk_out,  rk_tab[ei]);
        check_eq("rk_idx",  rk_idx,  ei);
        check_eq("rk_last", rk_last, (n == 10));
        if (poke && n == 2 && !poked) begin
          poked  = 1;
          start  = 1'b1;
          dec    = ~d;
          key_in = 128'hffffffff_00000000_12345678_9abcdef0;
        end
        n++;
        ei = d ? ei - 1 : ei + 1;
      end else if (gstall && !gdone && n == 1 && sbox_req) begin
        gdone    = 1;
        prev     = d ? ei + 1 : ei - 1;
        sbox_gnt = 1'b0;
        repeat (4) begin
          @(negedge clk); cyc++;
          check_eq("gstall_req",   sbox_req, 1);
          check_eq("gstall_valid", rk_valid, 0);
          check_eq("gstall_key",   rk_out,   rk_tab[prev]);
        end
        sbox_gnt = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    check_eq("job_keys", n, 11);
    check_eq("job_idle", busy, 0);
  endtask

  int p, cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; dec = 1'b0; key_in = '0;
    rk_ready = 1'b1; sbox_gnt = 1'b1;
    #12;
    check_reset_outputs("rst0");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);

    run_job(1'b0, -1, 1'b0, 1'b0, p);
    check_eq("enc_no_pre", p, 0);
    run_job(1'b1, -1, 1'b0, 1'b0, p);
    check_eq("dec_pre_cycles", p, 10);
    run_job(1'b0, 3, 1'b1, 1'b1, p);
    run_job(1'b1, 7, 1'b1, 1'b0, p);
`ifdef AES_KEY_CACHE_EN
    check_eq("dec_cache_hit_pre", p, 0);
`else
    check_eq("dec_again_pre", p, 10);
`endif

    // Reset in the middle of an encrypt job.
    @(negedge clk);
    dec = 1'b0; key_in = KEY0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(rk_valid && rk_idx == 4'd5) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check_eq("rst_reach_idx5", rk_idx, 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_no_resume", busy, 0);
    @(negedge clk);
    check_eq("rst_no_resume2", rk_valid, 0);

    run_job(1'b0, -1, 1'b0, 1'b0, p);
    run_job(1'b1, -1, 1'b0, 1'b0, p);
    check_eq("dec_after_rst_pre", p, 10);
    run_job(1'b1, -1, 1'b0, 1'b0, p);
`ifdef AES_KEY_CACHE_EN
    check_eq("dec_cache_hit_pre2", p, 0);
`else
    check_eq("dec_again_pre2", p, 10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_sequencer.md
AES_KEY_SEQUENCER -- requirements
Module: aes_key_sequencer

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of key-schedule rounds; only 10 (AES-128) is supported.
REQ-002 SHALL have ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle job request.
- dec, input, 1, order select: 0 = round keys 0..10, 1 = round keys 10..0; sampled with start.
- key_in, input, 128, cipher key; sampled with start.
- busy, output, 1, job in progress.
- rk_valid, output, 1, round key available.
- rk_ready, input, 1, consumer accepts the round key.
- rk_out, output, 128, current round key.
- rk_idx, output, 4, round number of rk_out.
- rk_last, output, 1, final key of the job.
- sbox_req, output, 1, request for the shared 32-bit S-box.
- sbox_gnt, input, 1, S-box granted this cycle.
- sub_in, output, 32, S-box operand.
- sub_out, input, 32, S-box result, combinational in the same cycle.

Function
REQ-003 SHALL implement FSM states IDLE, PRE, EMIT and STEP; busy SHALL be 1 in every state except IDLE.
REQ-004 In IDLE, start with dec=0 SHALL load key_in into the key register, set idx=0, and go to EMIT.
REQ-005 In IDLE, start with dec=1 SHALL load key_in, set idx=0, and go to PRE.
REQ-006 In PRE, each cycle with sbox_gnt=1 SHALL apply one forward step and increment idx; after the step giving idx=10, the FSM SHALL go to EMIT.
REQ-007 In EMIT, rk_valid SHALL be 1, rk_out SHALL equal the key register, and rk_idx SHALL equal idx.
REQ-008 rk_out and rk_idx SHALL be held stable while rk_valid=1 and rk_ready=0.
REQ-009 rk_last SHALL be 1 in EMIT when idx=10 (dec=0) or idx=0 (dec=1).
REQ-010 When rk_valid and rk_ready are both 1 and rk_last=1, the FSM SHALL go to IDLE; when rk_last=0, it SHALL go to STEP.
REQ-011 In STEP, sbox_req SHALL be 1; on sbox_gnt=1 the sequencer SHALL apply one step (forward if dec=0, inverse if dec=1), update idx by +1 or -1, and go to EMIT.
REQ-012 sbox_req SHALL be 1 only in PRE and STEP; the key register and idx SHALL NOT change in a cycle where sbox_gnt=0.
REQ-013 The forward step from idx SHALL use RCON[idx]; the inverse step from idx SHALL use RCON[idx-1]; RCON = 01,02,04,08,10,20,40,80,1b,36.
REQ-014 sub_in SHALL be driven by the step's G-function input word: word 3 of the current key for a forward step, word 3 of the result for an inverse step (w3^w2).
REQ-015 start SHALL be ignored while busy=1; sbox_gnt without sbox_req SHALL be ignored.
REQ-016 Minimum throughput SHALL be 1 round key per 2 cycles; a dec job SHALL take at least 10 extra cycles for PRE.

Reset
REQ-017 On rst_n=0, the FSM SHALL asynchronously return to IDLE, including mid-job; no partial job SHALL resume.
REQ-018 On rst_n=0, busy, rk_valid, rk_last and sbox_req SHALL be 0, and rk_out, rk_idx, sub_in, idx and the key register SHALL be 0.

Configuration
REQ-019 With AES_KEY_CACHE_EN defined, the sequencer SHALL hold the last round-10 key and its source key plus a valid bit, all cleared by reset.
REQ-020 With AES_KEY_CACHE_EN defined, a dec start whose key_in equals the cached source SHALL skip PRE and go directly to EMIT with idx=10.
REQ-021 Without AES_KEY_CACHE_EN, no cache storage SHALL exist and every dec job SHALL run PRE.

Structure
REQ-022 The shared AES package SHALL hold the state enum, the RCON table and the NR constant.
REQ-023 The design SHALL contain one combinational sub-module, aes_key_round (one forward or inverse round step, S-box exported through sub_in/sub_out); it SHALL be instantiated once.

Verification
REQ-024 Enc, key 000102..0f, rk_ready=1, gnt=1: 11 keys idx 0..10; key 10 = 13111d7fe3944a17f307a78b4d2b30c5; rk_last only at idx 10.
REQ-025 Dec, same key: first key idx 10 = 13111d7f...; last key idx 0 = 000102..0f; keys match REQ-024 in reverse.
REQ-026 rk_ready low for 5 cycles at idx 3: rk_out and rk_idx stable; no sbox_req until accept.
REQ-027 sbox_gnt low for 4 cycles in STEP: key unchanged and sbox_req held; the job completes with correct keys.
REQ-028 start pulsed mid-job with a different key: ignored; reset asserted at idx 5: all outputs 0, IDLE, and the next job is correct.
REQ-029 AES_KEY_CACHE_EN defined, two consecutive dec jobs with the same key: the second emits idx 10 with no PRE cycles (no sbox_req before the first rk_valid).
